mac_out_collector: RTL
======================

// Module: mac_out_collector
// PURPOSE
//   Drain-side receiver for the MAC array's south-edge outputs (out_s / valid).
//   The array emits per-column psums skewed in time: one column may be valid while its neighbours are not.
//   Each column's psum is captured into its own queue when that column's valid bit is high.
//   A full aligned row (one word per column) is presented to the downstream reader with a valid/rd handshake.
// PARAMETERS
//   col      8   number of array columns (one queue per column)
//   psum_bw  16  psum width per column
//   depth    8   entries per column queue; power of 2, >= 2
// PORTS
//   clk          in   1             rising-edge clock
//   reset        in   1             synchronous, active-high reset
//   in           in   psum_bw*col   psums from array out_s; column c = in[psum_bw*(c+1)-1 : psum_bw*c]
//   wr           in   col           per-column write strobes, driven from array valid
//   clr          in   1             synchronous flush of all queues (end of tile)
//   rd           in   1             pop one aligned row; honoured only when o_valid=1
//   out          out  psum_bw*col   aligned row, column c in the same slice as `in`
//   o_valid      out  1             every column queue is non-empty
//   o_full       out  1             at least one column queue is full
//   o_ready      out  1             ~o_full; upstream may keep issuing execute
//   o_overflow   out  1             sticky: a write strobe was dropped
// BEHAVIOUR
//   Storage
//     - Per column: a depth x psum_bw array, wr_ptr/rd_ptr of clog2(depth)+1 bits.
//     - The MSB of each pointer is a wrap bit.
//     - empty = (wr_ptr == rd_ptr).
//     - full  = (index bits equal) && (wrap bits differ).
//     - Pointers wrap modulo 2*depth; the storage index is the low clog2(depth) bits.
//   Reset / clr (same cycle effect)
//     - All pointers go to 0 and o_overflow goes to 0.
//     - Storage contents are don't-care.
//     - Afterwards o_valid=0, o_full=0, o_ready=1, out=0.
//     - reset takes priority over everything.
//     - clr takes priority over wr and rd in the same cycle, and discards the in-flight row.
//   Pop
//     - pop = rd & o_valid.
//     - On pop, every column's rd_ptr increments by 1 at the clock edge.
//     - rd while o_valid=0 is ignored: no state change, no error.
//   Push (column c)
//     - push[c] = wr[c] & (~full[c] | pop).
//     - A same-cycle pop frees a slot, so a full column still accepts the write.
//     - On push, mem[wr_ptr[c]] <= in slice c and wr_ptr[c] increments.
//     - wr[c] & full[c] & ~pop drops the data and sets o_overflow=1.
//     - o_overflow holds until reset or clr.
//   Simultaneous push+pop on an empty column
//     - Impossible, because o_valid requires all columns non-empty.
//     - The write lands normally.
//   Output timing
//     - First-word-fall-through.
//     - out = head entry of each column when o_valid=1; out = 0 when o_valid=0.
//     - A word written at edge N is visible at out after edge N.
//     - o_valid rises after the edge on which the last column receives its first word.
//     - Latency from wr to out: 1 cycle.
//   Flags
//     - o_valid, o_full and o_ready are combinational from the pointers.
//     - No dependence on current-cycle wr/rd, so there are no combinational paths from wr/rd to the flags.
//   Ordering
//     - Within a column, strict FIFO order.
//     - Row k of out is the k-th word written into every column, independent of inter-column skew.
// TESTING
//   1 Skewed fill
//     - Stimulus: col=8; pulse wr[c] at cycle t+c with in slice c = 16'h0100+c; no rd.
//     - Required: o_valid=0 until after cycle t+7, then 1.
//     - Required: out = {16'h0107,...,16'h0100}.
//   2 Pop
//     - Stimulus: after test 1, rd=1 for one cycle.
//     - Required: o_valid=0 and out=0 next cycle.
//     - Required: a second rd has no effect.
//   3 Full/overflow
//     - Stimulus: write column 0 nine times with depth=8 and no rd.
//     - Required: o_full=1 after the 8th write, o_ready=0.
//     - Required: 9th write dropped and o_overflow=1.
//     - Required: column 0 holds writes 1..8 in order.
//   4 Full + push + pop same cycle
//     - Stimulus: all columns full; wr=8'hFF with in=new row and rd=1 in the same cycle.
//     - Required: oldest row popped, new row accepted, o_full stays 1, o_overflow stays 0.
//   5 Wrap-around
//     - Stimulus: 20 rows streamed with rd concurrent, row k values = k.
//     - Required: out sequence 0..19 with no loss.
//     - Required: pointers wrap and o_overflow=0.
//   6 clr/reset mid-operation
//     - Stimulus: 3 rows queued plus o_overflow=1; assert clr together with wr and rd.
//     - Required: next cycle o_valid=0, o_overflow=0, out=0.
//     - Required: the written data is discarded.
//     - Repeat the same check with reset.

Source files
------------

// File: rtl/mac_out_collector.sv
// Drain-side collector for the MAC array's south-edge psums.
// Each column has its own first-word-fall-through queue; a row is presented only once every column holds a word.
module mac_out_collector #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   clr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_overflow
);

  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;

  logic [psum_bw-1:0] r_mem    [col][depth];
  logic [PW-1:0]      r_wr_ptr [col];
  logic [PW-1:0]      r_rd_ptr [col];
  logic               r_overflow;

  logic [col-1:0]     w_empty;
  logic [col-1:0]     w_full;
  logic [col-1:0]     w_push;
  logic [col-1:0]     w_drop;
  logic               w_valid;
  logic               w_pop;

  // Per-column status from pointers only; the MSB is the wrap bit.
  always_comb begin
    w_empty = '0;
    w_full  = '0;
    for (int c = 0; c < col; c++) begin
      w_empty[c] = (r_wr_ptr[c] == r_rd_ptr[c]);
      w_full[c]  = (r_wr_ptr[c][AW-1:0] == r_rd_ptr[c][AW-1:0]) &&
                   (r_wr_ptr[c][AW] != r_rd_ptr[c][AW]);
    end
  end

  // A same-cycle pop frees a slot, so a full column may still accept its write.
  always_comb begin
    w_valid = ~|w_empty;
    w_pop   = rd & w_valid;
    w_push  = wr & (~w_full | {col{w_pop}});
    w_drop  = wr & w_full & ~{col{w_pop}};
  end

  // Head of every column, forced to zero while no aligned row exists.
  always_comb begin
    out = '0;
    for (int c = 0; c < col; c++) begin
      if (w_valid) begin
        out[c*psum_bw +: psum_bw] = r_mem[c][r_rd_ptr[c][AW-1:0]];
      end else begin
        out[c*psum_bw +: psum_bw] = '0;
      end
    end
  end

  always_comb begin
    o_valid    = w_valid;
    o_full     = |w_full;
    o_ready    = ~(|w_full);
    o_overflow = r_overflow;
  end

  // Pointer update; reset and clr flush the queues and discard in-flight traffic.
  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++) begin
      if (reset || clr) begin
        r_wr_ptr[c] <= {PW{1'b0}};
        r_rd_ptr[c] <= {PW{1'b0}};
      end else begin
        if (w_push[c]) begin
          r_wr_ptr[c] <= r_wr_ptr[c] + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr[c] <= r_rd_ptr[c] + PW'(1);
        end
      end
    end
  end

  // Storage has no reset; stale words are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++) begin
      if (w_push[c] && !reset && !clr) begin
        r_mem[c][r_wr_ptr[c][AW-1:0]] <= in[c*psum_bw +: psum_bw];
      end
    end
  end

  // Sticky record of any dropped write strobe.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_overflow <= 1'b0;
    end else if (|w_drop) begin
      r_overflow <= 1'b1;
    end
  end

endmodule
